serial_alu_sched: RTL and testbench
===================================

Name: serial_alu_sched

Overview:
- Round-robin scheduler sharing one bit-serial 8-bit ALU (8 shift cycles per op) between N requesters.
- Accepts at most one op at a time and drives the ALU's din_* handshake.
- Captures the one-cycle ALU result pulse and routes it to the issuing requester.
- Holds each result in a per-requester response register until the requester accepts it (valid/ready).

Parameters:
- N, 4: number of requesters; N >= 2. Localparam IW = clog2(N), the owner index width.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset. The same net also drives the ALU's (synchronous) reset.
- req_vld  in  N  request valid, one bit per requester.
- req_rdy  out  N  request accepted this cycle; at most one bit set.
- req_di1  in  8*N  operand 1; requester i uses bits [8i+7:8i].
- req_di2  in  8*N  operand 2, same packing.
- req_fun  in  2*N  function code; requester i uses bits [2i+1:2i].
- resp_vld  out  N  result held for requester i.
- resp_rdy  in  N  requester i consumes its result.
- resp_dat  out  8*N  held result, same packing as req_di1.
- alu_din_di1, alu_din_di2  out  8  operands to the ALU.
- alu_din_fun  out  2  function code to the ALU.
- alu_din_vld  out  1  issue strobe to the ALU.
- alu_din_rdy  in  1  ALU idle.
- alu_dout_dat  in  8  ALU result.
- alu_dout_vld  in  1  ALU result strobe; one-cycle pulse.
- busy  out  1  an op is in flight (state WAIT).

Behaviour:
- FSM has two states.
  - IDLE: may issue an op.
  - WAIT: op in flight; owner register holds the requester index.
- Eligibility: eligible[i] = req_vld[i] && !resp_vld[i].
  - Sampled at the start of the cycle.
  - A slot being freed that same cycle does not make requester i eligible until the next cycle.
- Grant, in IDLE with alu_din_rdy=1 and any eligible requester:
  - Pick the first eligible index searching upward from (last_grant+1) mod N, wrapping.
  - Combinationally: req_rdy[g]=1, alu_din_vld=1, alu_din_* = requester g's operands and function code.
  - On the clock edge: owner<=g, last_grant<=g, state<=WAIT.
- In IDLE with alu_din_rdy=0 or nothing eligible: req_rdy=0 and alu_din_vld=0.
- alu_din_* are don't-care whenever alu_din_vld=0; drive them from requester 0 to avoid X.
- WAIT:
  - req_rdy=0 and alu_din_vld=0.
  - On alu_dout_vld=1: resp_dat[owner]<=alu_dout_dat, resp_vld[owner]<=1, state<=IDLE.
  - No issue in the completion cycle.
- alu_dout_vld seen in IDLE is ignored; no response slot changes.
- Timing:
  - Accept at edge T0 gives alu_dout_vld in cycle T0+9 and resp_vld high from cycle T0+10.
  - The next issue is possible in cycle T0+10, giving a 10-cycle throughput per op.
- Response slot i: cleared when resp_vld[i] && resp_rdy[i].
  - A capture and a clear of the same slot cannot coincide, because the owner's slot is empty at grant.
  - resp_dat[i] holds its value until the next capture for requester i.
- Function codes are passed through unchanged; the scheduler never interprets them.
- Reset state (asynchronous):
  - state=IDLE, last_grant=N-1 so requester 0 has first priority, owner=0.
  - resp_vld=0, resp_dat=0, busy=0.
  - req_rdy=0 and alu_din_vld=0 while reset is high.
- Reset mid-op: the in-flight op is discarded, no response is produced, and the ALU is reset by the same net.
- After reset deasserts, the first issue waits for alu_din_rdy=1.
- Requester fairness: a continuously eligible requester is granted within N grants.

Decomposition:
- Package serial_alu_pkg:
  - ALU_DW=8 and ALU_SHIFTS=8.
  - FUN_ADD=2'd0, FUN_AND=2'd1, FUN_OR=2'd2, FUN_F3=2'd3.
  - Scheduler state encoding SCHED_IDLE / SCHED_WAIT.
- Sub-module serial_alu_rr_pick: combinational round-robin picker.
  - Inputs: eligible[N], last_grant[IW].
  - Outputs: any, grant_idx[IW].
  - Instantiated once.
- The bench instantiates serial_alu_sched together with the real ALU.

Test Plan:
- Single op: requester 1 issues ADD 8'h5A+8'h33 → req_rdy[1] at T0, resp_vld[1] at T0+10, resp_dat[1]=8'h8D, other resp_vld stay 0.
- Wrap-around add: requester 0 issues ADD 8'hFF+8'h01 → resp_dat[0]=8'h00 (carry dropped). AND 8'hF0&8'h3C → 8'h30. OR 8'h0F|8'h30 → 8'h3F.
- Round-robin: all 4 requesters hold req_vld with resp_rdy=1 → grant order 0,1,2,3,0, grants 10 cycles apart, each result matches its own operands.
- Backpressure: requester 2 holds resp_rdy=0 with req_vld=1 → after its first result, requester 2 is not granted again and the others proceed. Raising resp_rdy[2] clears the slot, and requester 2 is granted on a later pass.
- Reset at T0+4 mid-op → busy=0 and all resp_vld=0 immediately. No response for the aborted op. After deassert, a new ADD 8'h01+8'h02 returns 8'h03.
- Stale pulse: force alu_dout_vld=1 while IDLE (ALU stubbed) → no resp_vld change and no state change.

Source files
------------

// File: rtl/serial_alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_alu_pkg                                                  |
// | Purpose  : Shared constants and scheduler state encoding for serial ALU.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
package serial_alu_pkg;

    localparam int ALU_DW     = 8;
    localparam int ALU_SHIFTS = 8;

    localparam logic [1:0] FUN_ADD = 2'd0;
    localparam logic [1:0] FUN_AND = 2'd1;
    localparam logic [1:0] FUN_OR  = 2'd2;
    localparam logic [1:0] FUN_F3  = 2'd3;

    typedef enum logic [0:0] {
        SCHED_IDLE = 1'b0,
        SCHED_WAIT = 1'b1
    } sched_state_e;

endpackage : serial_alu_pkg
`default_nettype wire

// File: rtl/serial_alu_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_alu_rr_pick                                              |
// | Purpose  : Combinational round-robin picker starting after last_grant.     |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module serial_alu_rr_pick #(
    parameter  int N  = 4,
    localparam int IW = $clog2(N)
) (
    input  logic [N-1:0]  eligible,
    input  logic [IW-1:0] last_grant,
    output logic          any,
    output logic [IW-1:0] grant_idx
);

    // Scan offsets from farthest to nearest so the nearest eligible index wins.
    always_comb begin
        any       = 1'b0;
        grant_idx = '0;
        for (int k = N; k >= 1; k--) begin
            for (int i = 0; i < N; i++) begin
                if (eligible[i] && (((int'(last_grant) + k) % N) == i)) begin
                    any       = 1'b1;
                    grant_idx = IW'(i);
                end
            end
        end
    end

endmodule : serial_alu_rr_pick
`default_nettype wire

// File: rtl/serial_alu_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : serial_alu_sched                                                |
// | Purpose  : Round-robin sharing of one bit-serial ALU between N requesters. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module serial_alu_sched
    import serial_alu_pkg::*;
#(
    parameter int N = 4
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [N-1:0]          req_vld,
    output logic [N-1:0]          req_rdy,
    input  logic [ALU_DW*N-1:0]   req_di1,
    input  logic [ALU_DW*N-1:0]   req_di2,
    input  logic [2*N-1:0]        req_fun,
    output logic [N-1:0]          resp_vld,
    input  logic [N-1:0]          resp_rdy,
    output logic [ALU_DW*N-1:0]   resp_dat,
    output logic [ALU_DW-1:0]     alu_din_di1,
    output logic [ALU_DW-1:0]     alu_din_di2,
    output logic [1:0]            alu_din_fun,
    output logic                  alu_din_vld,
    input  logic                  alu_din_rdy,
    input  logic [ALU_DW-1:0]     alu_dout_dat,
    input  logic                  alu_dout_vld,
    output logic                  busy
);

    localparam int IW = $clog2(N);

    sched_state_e          state_q, state_d;
    logic [IW-1:0]         owner_q, owner_d;
    logic [IW-1:0]         last_grant_q, last_grant_d;
    logic [N-1:0]          resp_vld_q, resp_vld_d;
    logic [ALU_DW*N-1:0]   resp_dat_q, resp_dat_d;
    logic                  busy_q, busy_d;

    logic [N-1:0]          w_eligible;
    logic                  w_pick_any;
    logic [IW-1:0]         w_pick_idx;
    logic                  w_issue;

    // A slot freed this cycle only counts as empty from the next cycle on.
    assign w_eligible = req_vld & ~resp_vld_q;

    serial_alu_rr_pick #(
        .N (N)
    ) u_pick (
        .eligible   (w_eligible),
        .last_grant (last_grant_q),
        .any        (w_pick_any),
        .grant_idx  (w_pick_idx)
    );

    assign w_issue = !reset && (state_q == SCHED_IDLE) && alu_din_rdy && w_pick_any;
    assign alu_din_vld = w_issue;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_req_rdy
            assign req_rdy[gi] = w_issue && (w_pick_idx == IW'(gi));
        end
    endgenerate

    // Requester 0 feeds the ALU operands whenever nothing is issued.
    always_comb begin
        alu_din_di1 = req_di1[ALU_DW-1:0];
        alu_din_di2 = req_di2[ALU_DW-1:0];
        alu_din_fun = req_fun[1:0];
        for (int i = 0; i < N; i++) begin
            if (w_issue && (w_pick_idx == IW'(i))) begin
                alu_din_di1 = req_di1[i*ALU_DW +: ALU_DW];
                alu_din_di2 = req_di2[i*ALU_DW +: ALU_DW];
                alu_din_fun = req_fun[i*2 +: 2];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        last_grant_d = last_grant_q;
        resp_vld_d   = resp_vld_q & ~resp_rdy;
        resp_dat_d   = resp_dat_q;
        case (state_q)
            SCHED_IDLE: begin
                if (w_issue) begin
                    owner_d      = w_pick_idx;
                    last_grant_d = w_pick_idx;
                    state_d      = SCHED_WAIT;
                end
            end
            SCHED_WAIT: begin
                if (alu_dout_vld) begin
                    for (int i = 0; i < N; i++) begin
                        if (owner_q == IW'(i)) begin
                            resp_vld_d[i]                     = 1'b1;
                            resp_dat_d[i*ALU_DW +: ALU_DW]    = alu_dout_dat;
                        end
                    end
                    state_d = SCHED_IDLE;
                end
            end
            default: state_d = SCHED_IDLE;
        endcase
        busy_d = (state_d == SCHED_WAIT);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= SCHED_IDLE;
            owner_q      <= '0;
            last_grant_q <= IW'(N-1);
            resp_vld_q   <= '0;
            resp_dat_q   <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            resp_vld_q   <= resp_vld_d;
            resp_dat_q   <= resp_dat_d;
            busy_q       <= busy_d;
        end
    end

    assign resp_vld = resp_vld_q;
    assign resp_dat = resp_dat_q;
    assign busy     = busy_q;

endmodule : serial_alu_sched
`default_nettype wire

// File: tb/tb_serial_alu_sched.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_serial_alu_sched                                             |
// | Purpose  : Directed self-checking bench: scheduler plus behavioural ALU.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_serial_alu_sched;
    import serial_alu_pkg::*;

    localparam int N = 4;

    logic                clock = 1'b0;
    logic                reset;
    logic [N-1:0]        req_vld, req_rdy, resp_vld, resp_rdy;
    logic [8*N-1:0]      req_di1, req_di2, resp_dat;
    logic [2*N-1:0]      req_fun;
    logic [7:0]          alu_din_di1, alu_din_di2, alu_dout_dat;
    logic [1:0]          alu_din_fun;
    logic                alu_din_vld, alu_din_rdy, alu_dout_vld, busy;

    int n_cmp = 0;
    int n_err = 0;

    logic       alu_stub, stub_vld;
    logic [7:0] stub_dat;
    logic       alu_busy;
    logic [3:0] alu_cnt;
    logic [7:0] alu_a, alu_b, alu_res;
    logic [1:0] alu_f;

    always #5 clock = ~clock;

    serial_alu_sched #(.N(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .req_vld      (req_vld),
        .req_rdy      (req_rdy),
        .req_di1      (req_di1),
        .req_di2      (req_di2),
        .req_fun      (req_fun),
        .resp_vld     (resp_vld),
        .resp_rdy     (resp_rdy),
        .resp_dat     (resp_dat),
        .alu_din_di1  (alu_din_di1),
        .alu_din_di2  (alu_din_di2),
        .alu_din_fun  (alu_din_fun),
        .alu_din_vld  (alu_din_vld),
        .alu_din_rdy  (alu_din_rdy),
        .alu_dout_dat (alu_dout_dat),
        .alu_dout_vld (alu_dout_vld),
        .busy         (busy)
    );

    // Serial ALU timing: loaded at the accept edge, result pulse 9 cycles later.
    always @(posedge clock) begin
        if (reset) begin
            alu_busy <= 1'b0;
            alu_cnt  <= '0;
            alu_a    <= '0;
            alu_b    <= '0;
            alu_f    <= '0;
        end else if (!alu_busy) begin
            if (alu_din_vld) begin
                alu_busy <= 1'b1;
                alu_cnt  <= '0;
                alu_a    <= alu_din_di1;
                alu_b    <= alu_din_di2;
                alu_f    <= alu_din_fun;
            end
        end else if (alu_cnt == 4'(ALU_SHIFTS)) begin
            alu_busy <= 1'b0;
        end else begin
            alu_cnt <= alu_cnt + 4'd1;
        end
    end

    always_comb begin
        case (alu_f)
            FUN_ADD: alu_res = alu_a + alu_b;
            FUN_AND: alu_res = alu_a & alu_b;
            FUN_OR:  alu_res = alu_a | alu_b;
            default: alu_res = alu_a ^ alu_b;
        endcase
    end

    assign alu_din_rdy  = !alu_busy;
    assign alu_dout_vld = alu_stub ? stub_vld : (alu_busy && (alu_cnt == 4'(ALU_SHIFTS)));
    assign alu_dout_dat = alu_stub ? stub_dat : alu_res;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge clock);
    endtask

    task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b, input logic [1:0] f);
        req_di1[i*8 +: 8] = a;
        req_di2[i*8 +: 8] = b;
        req_fun[i*2 +: 2] = f;
        req_vld[i]        = 1'b1;
    endtask

    // Starts in the grant cycle, ends in cycle T0+10 with the result captured.
    task automatic grant_step(input int g, input logic [7:0] exp, input bit drop);
        chk("grant_rdy", 32'(req_rdy), 32'(1 << g));
        chk("grant_din_vld", 32'(alu_din_vld), 32'd1);
        chk("grant_di1", 32'(alu_din_di1), 32'(req_di1[g*8 +: 8]));
        chk("grant_di2", 32'(alu_din_di2), 32'(req_di2[g*8 +: 8]));
        chk("grant_fun", 32'(alu_din_fun), 32'(req_fun[g*2 +: 2]));
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (drop && k == 1) req_vld = '0;
            #1;
            if (k == 1) chk("busy_t1", 32'(busy), 32'd1);
            if (k == 9) begin
                chk("busy_t9", 32'(busy), 32'd1);
                chk("no_resp_t9", 32'(resp_vld[g]), 32'd0);
            end
        end
        tick();
        #1;
        chk("resp_vld_t10", 32'(resp_vld[g]), 32'd1);
        chk("resp_dat_t10", 32'(resp_dat[g*8 +: 8]), 32'(exp));
        chk("busy_t10", 32'(busy), 32'd0);
    endtask

    task automatic consume(input int g, input logic [7:0] exp);
        resp_rdy[g] = 1'b1;
        tick();
        resp_rdy[g] = 1'b0;
        #1;
        chk("consume_vld", 32'(resp_vld[g]), 32'd0);
        chk("consume_dat_hold", 32'(resp_dat[g*8 +: 8]), 32'(exp));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int seq_rr[5];
        int seq_bp[9];
        seq_rr = '{0, 1, 2, 3, 0};
        seq_bp = '{1, 2, 3, 0, 1, 3, 0, 1, 2};

        reset    = 1'b1;
        req_vld  = '0;
        resp_rdy = '0;
        req_di1  = '0;
        req_di2  = '0;
        req_fun  = '0;
        alu_stub = 1'b0;
        stub_vld = 1'b0;
        stub_dat = '0;

        // Reset state, with requests present to show they are masked.
        repeat (2) tick();
        req_vld = 4'hF;
        #1;
        chk("rst_req_rdy", 32'(req_rdy), 32'd0);
        chk("rst_din_vld", 32'(alu_din_vld), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_vld", 32'(resp_vld), 32'd0);
        chk("rst_resp_dat", resp_dat, 32'd0);
        req_vld = '0;
        tick();
        reset = 1'b0;

        // Single op: requester 1 ADD 5A+33
        set_req(1, 8'h5A, 8'h33, FUN_ADD);
        #1;
        grant_step(1, 8'h8D, 1'b1);
        chk("single_others", 32'(resp_vld), 32'h2);
        consume(1, 8'h8D);

        // Function coverage: wrap-around add, AND, OR
        set_req(0, 8'hFF, 8'h01, FUN_ADD);
        #1;
        grant_step(0, 8'h00, 1'b1);
        consume(0, 8'h00);
        set_req(2, 8'hF0, 8'h3C, FUN_AND);
        #1;
        grant_step(2, 8'h30, 1'b1);
        consume(2, 8'h30);
        set_req(3, 8'h0F, 8'h30, FUN_OR);
        #1;
        grant_step(3, 8'h3F, 1'b1);
        consume(3, 8'h3F);

        // Round-robin with all requesters active
        for (int i = 0; i < N; i++) set_req(i, 8'((i + 1) * 16), 8'(i + 1), FUN_ADD);
        resp_rdy = 4'hF;
        #1;
        for (int s = 0; s < 5; s++) grant_step(seq_rr[s], 8'((seq_rr[s] + 1) * 17), s == 4);

        // Backpressure on requester 2
        resp_rdy = 4'b1011;
        req_vld  = 4'hF;
        #1;
        for (int s = 0; s < 9; s++) begin
            if (s == 5) chk("bp_held2", 32'(resp_vld[2]), 32'd1);
            if (s == 6) resp_rdy[2] = 1'b1;
            grant_step(seq_bp[s], 8'((seq_bp[s] + 1) * 17), s == 8);
        end
        tick();
        #1;
        chk("bp_all_clear", 32'(resp_vld), 32'd0);

        // Stale result pulse while idle
        alu_stub = 1'b1;
        stub_vld = 1'b1;
        stub_dat = 8'hAA;
        tick();
        stub_vld = 1'b0;
        alu_stub = 1'b0;
        #1;
        chk("stale_resp_vld", 32'(resp_vld), 32'd0);
        chk("stale_busy", 32'(busy), 32'd0);
        chk("stale_resp_dat", resp_dat, 32'h44332211);

        // Still idle: a fresh op issues at once and is left held
        resp_rdy = '0;
        set_req(3, 8'h20, 8'h02, FUN_OR);
        #1;
        grant_step(3, 8'h22, 1'b1);

        // Reset in the middle of an op
        set_req(1, 8'h5A, 8'h33, FUN_ADD);
        #1;
        chk("abort_grant", 32'(req_rdy), 32'h2);
        tick();
        req_vld = '0;
        repeat (3) tick();
        reset = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_resp_vld", 32'(resp_vld), 32'd0);
        chk("abort_resp_dat", resp_dat, 32'd0);
        chk("abort_req_rdy", 32'(req_rdy), 32'd0);
        repeat (2) tick();
        reset = 1'b0;
        repeat (12) tick();
        #1;
        chk("abort_no_resp", 32'(resp_vld), 32'd0);
        chk("abort_idle", 32'(busy), 32'd0);
        set_req(0, 8'h01, 8'h02, FUN_ADD);
        #1;
        grant_step(0, 8'h03, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule : tb_serial_alu_sched
`default_nettype wire
